regfile_mp: RTL and testbench

//  Multi-read-port RV32 integer register file for the single-cycle/pipelined core; replaces the 2-read regfile.

---
 rtl/regfile_mp.sv | 147 ++++++++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: RV32 integer register file with NUM_READ combinational read
// ports, hardwired x0, async active-low reset, a sequential clear engine and
// an optional same-cycle write-to-read bypass (define REGFILE_BYPASS_EN).
// Default build (REGFILE_BYPASS_EN undefined): read-before-write.

// One read port: x0 reads zero, optional write-first forwarding of wdata.
module regfile_mp_rd_port #(
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int DEPTH = 32
) (
   input  logic [DEPTH-1:0][DW-1:0] rf,
   input  logic [AW-1:0]            raddr,
   input  logic                     byp_en,
   input  logic [AW-1:0]            waddr,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata
);

   // read mux; forwarding wins over the stored value when the write is live
   always_comb begin
      rdata = '0;
      if (raddr != '0) begin
         if (byp_en && (raddr == waddr)) rdata = wdata;
         else                            rdata = rf[raddr];
      end
   end

endmodule

module regfile_mp #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_READ      = 2,
   parameter int DEBUG_REG     = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_READ*ADDRESS_WIDTH-1:0] raddr,
   output logic [NUM_READ*DATA_WIDTH-1:0]    rdata,
   input  logic                              we,
   input  logic [ADDRESS_WIDTH-1:0]          waddr,
   input  logic [DATA_WIDTH-1:0]             wdata,
   input  logic                              clr_req,
   output logic                              clr_busy,
   output logic [DATA_WIDTH-1:0]             dbg_reg
);

   localparam int AW    = ADDRESS_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int DEPTH = 2**AW;
   localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e                  state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic [DEPTH-1:0][DW-1:0] regs_q, regs_d;
   logic                    wr_live;
   logic                    byp_en;

   // external write is accepted only in IDLE and never to x0
   assign wr_live = we && (waddr != '0) && (state_q == IDLE);

`ifdef REGFILE_BYPASS_EN
   assign byp_en = wr_live;
`else
   assign byp_en = 1'b0;
`endif

   // next-state: external writes in IDLE, one register wiped per cycle in CLEAR
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      regs_d  = regs_q;
      case (state_q)
         IDLE: begin
            if (wr_live) regs_d[waddr] = wdata;
            // a write in the same cycle still lands; the wipe reaches it later
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = AW'(1);
               busy_d  = 1'b1;
            end
         end
         CLEAR: begin
            // cnt starts at 1 and exits at max, so x0 is never touched
            regs_d[cnt_q] = '0;
            if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q + AW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state registers; reset aborts any clear in progress and zeroes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         regs_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         regs_q  <= regs_d;
      end
   end

   assign clr_busy = busy_q;

   // per-port read logic, one instance per lane
   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      regfile_mp_rd_port #(
         .AW   (AW),
         .DW   (DW),
         .DEPTH(DEPTH)
      ) u_rd (
         .rf    (regs_q),
         .raddr (raddr[i*AW +: AW]),
         .byp_en(byp_en),
         .waddr (waddr),
         .wdata (wdata),
         .rdata (rdata[i*DW +: DW])
      );
   end

   // debug tap of the stored value, no forwarding
   if (DEBUG_REG == 0) begin : g_dbg_zero
      assign dbg_reg = '0;
   end else begin : g_dbg
      assign dbg_reg = regs_q[DEBUG_REG];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp at default parameters.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        clr_req;
   logic        clr_busy;
   logic [31:0] dbg_reg;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt;

   regfile_mp dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .raddr   (raddr),
      .rdata   (rdata),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .clr_req (clr_req),
      .clr_busy(clr_busy),
      .dbg_reg (dbg_reg)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty got %h want <none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s got %h want %h", e.tag, obs, e.val);
         end
      end
   endtask

   // advance past the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_all();
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = 32'(i);
         step();
      end
      we = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
      #3;
      // reset state
      push("rst_busy", 32'd0); push("rst_dbg", 32'd0); push("rst_rd0", 32'd0);
      pop_chk({31'd0, clr_busy}); pop_chk(dbg_reg); pop_chk(rdata[31:0]);
      rst_n = 1'b1;
      step();

      // 1: async reset wipes a written value immediately
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; step();
      waddr = 5'd10; wdata = 32'h0000CAFE; step();
      we = 1'b0; raddr = {5'd10, 5'd5};
      push("t1_x5_pre", 32'hDEADBEEF); push("t1_dbg_pre", 32'h0000CAFE);
      #1; pop_chk(rdata[31:0]); pop_chk(dbg_reg);
      #1 rst_n = 1'b0;
      push("t1_x5_rst", 32'd0); push("t1_x10_rst", 32'd0); push("t1_dbg_rst", 32'd0);
      #1; pop_chk(rdata[31:0]); pop_chk(rdata[63:32]); pop_chk(dbg_reg);
      rst_n = 1'b1;
      step();

      // 2: writes to x0 are dropped, no forwarding on x0
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = '0;
      push("t2_x0_same", 32'd0);
      #1; pop_chk(rdata[31:0]);
      step(); we = 1'b0;
      push("t2_x0_next", 32'd0); push("t2_dbg", 32'd0);
      #1; pop_chk(rdata[31:0]); pop_chk(dbg_reg);

      // 3: write then read on port 1 and debug tap
      we = 1'b1; waddr = 5'd10; wdata = 32'h12345678;
      step(); we = 1'b0; raddr = {5'd10, 5'd11};
      push("t3_rd1_x10", 32'h12345678); push("t3_dbg", 32'h12345678); push("t3_rd0_x11", 32'd0);
      #1; pop_chk(rdata[63:32]); pop_chk(dbg_reg); pop_chk(rdata[31:0]);

      // 4: same-cycle read of the register being written
      we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd7};
`ifdef REGFILE_BYPASS_EN
      push("t4_byp_rd0", 32'hA5A5A5A5); push("t4_byp_rd1", 32'hA5A5A5A5);
`else
      push("t4_old_rd0", 32'd0); push("t4_old_rd1", 32'd0);
`endif
      #1; pop_chk(rdata[31:0]); pop_chk(rdata[63:32]);
      step(); we = 1'b0;
      push("t4_next_rd0", 32'hA5A5A5A5); push("t4_next_rd1", 32'hA5A5A5A5);
      #1; pop_chk(rdata[31:0]); pop_chk(rdata[63:32]);

      // 5: full sequential clear
      fill_all();
      raddr = {5'd31, 5'd1};
      push("t5_fill_x1", 32'd1); push("t5_fill_x31", 32'd31);
      #1; pop_chk(rdata[31:0]); pop_chk(rdata[63:32]);
      clr_req = 1'b1;
      push("t5_busy_pre", 32'd0);
      pop_chk({31'd0, clr_busy});
      step(); clr_req = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k <= 30; k++) begin
         // after k cycles of clearing: x1..xk zero, x(k+1) untouched
         raddr[9:5] = 5'(k + 1);
         raddr[4:0] = (k == 6) ? 5'd3 : 5'(k);
         if (k == 5) begin
            // write during clear: dropped and never forwarded
            we = 1'b1; waddr = 5'd3; wdata = 32'h00000333; raddr[4:0] = 5'd3;
         end
         if (k == 10) clr_req = 1'b1;
         push("t5_busy", 32'd1);
         push($sformatf("t5_k%0d_lo", k), 32'd0);
         push($sformatf("t5_k%0d_hi", k), 32'(k + 1));
         #1;
         if (clr_busy) busy_cnt++;
         pop_chk({31'd0, clr_busy}); pop_chk(rdata[31:0]); pop_chk(rdata[63:32]);
         step(); we = 1'b0; clr_req = 1'b0;
      end
      push("t5_busy_done", 32'd0); push("t5_busy_cycles", 32'd31);
      pop_chk({31'd0, clr_busy}); pop_chk(32'(busy_cnt));
      for (int i = 1; i < 32; i += 2) begin
         raddr = {5'(i + 1 < 32 ? i + 1 : 1), 5'(i)};
         push($sformatf("t5_end_x%0d", i), 32'd0);
         #1; pop_chk(rdata[31:0]);
      end
      push("t5_x0_kept", 32'd0);
      raddr = '0; #1; pop_chk(rdata[31:0]);

      // 6: reset in the middle of a clear
      fill_all();
      clr_req = 1'b1; step(); clr_req = 1'b0;
      repeat (9) step();
      push("t6_busy_mid", 32'd1); push("t6_x12_mid", 32'd12);
      raddr = {5'd0, 5'd12}; #1;
      pop_chk({31'd0, clr_busy}); pop_chk(rdata[31:0]);
      #1 rst_n = 1'b0;
      #1;
      push("t6_busy_rst", 32'd0);
      pop_chk({31'd0, clr_busy});
      for (int i = 20; i < 32; i += 5) begin
         raddr = {5'd0, 5'(i)};
         push($sformatf("t6_rst_x%0d", i), 32'd0);
         #1; pop_chk(rdata[31:0]);
      end
      rst_n = 1'b1;
      step();
      we = 1'b1; waddr = 5'd1; wdata = 32'h11; step();
      waddr = 5'd2; wdata = 32'h22; step();
      we = 1'b0; clr_req = 1'b1; step(); clr_req = 1'b0;
      raddr = {5'd2, 5'd1};
      push("t6_restart_x1_k0", 32'h11); push("t6_restart_busy", 32'd1);
      #1; pop_chk(rdata[31:0]); pop_chk({31'd0, clr_busy});
      step();
      push("t6_restart_x1_k1", 32'd0); push("t6_restart_x2_k1", 32'h22);
      #1; pop_chk(rdata[31:0]); pop_chk(rdata[63:32]);
      begin : wait_idle
         int n;
         n = 0;
         while (clr_busy && n < 40) begin
            step();
            n++;
         end
         push("t6_finish_busy", 32'd0);
         pop_chk({31'd0, clr_busy});
      end
      push("t6_end_x2", 32'd0);
      #1; pop_chk(rdata[63:32]);

      if (sb.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard bound so a stuck run still terminates
   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
